// File: rtl/filter_pass_scheduler_pkg.sv
// Shared definitions for the FIR pass scheduler:
// FSM state encoding, default pipeline latencies, channel-index width.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MAC     = 2'd1,
    DRAIN   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int MAC_LAT_DEF = 1;
  localparam int RT_LAT_DEF  = 3;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filter_pass_scheduler_if.sv
// Bus between the pass scheduler and the shared
// MAC / accumulator / round-truncate datapath.
interface filter_pass_scheduler_if #(
  parameter int TAP_W = 7,
  parameter int CH_W  = 1
);

  logic             mac_clr;
  logic             mac_en;
  logic [TAP_W-1:0] tap_addr;
  logic [CH_W-1:0]  mac_ch;
  logic [15:0]      rt_data;
  logic             rt_ovf;
  logic             rt_ovf_clear;

  modport master (
    output mac_clr,
    output mac_en,
    output tap_addr,
    output mac_ch,
    output rt_ovf_clear,
    input  rt_data,
    input  rt_ovf
  );

  modport slave (
    input  mac_clr,
    input  mac_en,
    input  tap_addr,
    input  mac_ch,
    input  rt_ovf_clear,
    output rt_data,
    output rt_ovf
  );

endinterface

// File: rtl/filter_pass_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting
// index at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter
  import filter_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  int idx;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (en && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/filter_pass_scheduler.sv
// Time-shares one FIR datapath between NUM_CH channels:
// grant, walk taps, drain pipeline, capture result.
module filter_pass_scheduler
  import filter_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int TAP_W   = 7,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int RT_LAT  = RT_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_req,
  output logic [NUM_CH-1:0]    ch_ack,
  input  logic [TAP_W-1:0]     rf_num_taps,
  filter_pass_scheduler_if.master dp,
  output logic [16*NUM_CH-1:0] ch_out,
  output logic [NUM_CH-1:0]    ch_ovf,
  input  logic [NUM_CH-1:0]    ch_ovf_clear
);

  localparam int CH_W      = ch_w(NUM_CH);
  localparam int DRAIN_LEN = MAC_LAT + RT_LAT;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt_ch;
  logic [TAP_W-1:0] last_tap;
  logic [TAP_W-1:0] tap_q;
  logic [DW-1:0]    drain_cnt;
  logic             mac_en_q;
  logic             mac_clr_q;
  logic             ovf_clr_q;

  logic [CH_W-1:0]  arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req         (ch_req),
    .ptr         (rr_ptr),
    .en          (state == IDLE),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign dp.mac_en       = mac_en_q;
  assign dp.mac_clr      = mac_clr_q;
  assign dp.tap_addr     = tap_q;
  assign dp.mac_ch       = gnt_ch;
  assign dp.rt_ovf_clear = ovf_clr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_ch    <= '0;
      last_tap  <= '0;
      tap_q     <= '0;
      drain_cnt <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      ovf_clr_q <= 1'b0;
      ch_ack    <= '0;
      ch_out    <= '0;
      ch_ovf    <= '0;
    end else begin
      ch_ack    <= '0;
      ovf_clr_q <= 1'b0;
      // a capture set later in this block overrides the clear
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_ovf_clear[i]) ch_ovf[i] <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            state     <= MAC;
            gnt_ch    <= arb_idx;
            last_tap  <= (rf_num_taps == '0) ? '0
                       : rf_num_taps - TAP_W'(1);
            tap_q     <= '0;
            mac_en_q  <= 1'b1;
            mac_clr_q <= 1'b1;
          end
        end
        MAC: begin
          mac_clr_q <= 1'b0;
          if (tap_q == last_tap) begin
            state     <= DRAIN;
            mac_en_q  <= 1'b0;
            tap_q     <= '0;
            drain_cnt <= DW'(DRAIN_LEN - 1);
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= CAPTURE;
            ovf_clr_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        CAPTURE: begin
          state  <= IDLE;
          rr_ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0
                  : gnt_ch + CH_W'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == gnt_ch) begin
              ch_out[16*i +: 16] <= dp.rt_data;
              ch_ack[i]          <= 1'b1;
              if (dp.rt_ovf) ch_ovf[i] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_pass_scheduler.sv
// Directed bench for filter_pass_scheduler with an
// ack scoreboard keyed on expected channel and cycle.
module tb_filter_pass_scheduler;

  typedef struct {
    int          ch;
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ch_req;
  logic [1:0]  ch_ack;
  logic [6:0]  rf_num_taps;
  logic [31:0] ch_out;
  logic [1:0]  ch_ovf;
  logic [1:0]  ch_ovf_clear;
  logic        rt_auto;
  logic [15:0] rt_fixed;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];
  exp_t mon_e;

  filter_pass_scheduler_if #(.TAP_W(7), .CH_W(1)) dp ();

  filter_pass_scheduler #(
    .NUM_CH  (2),
    .TAP_W   (7),
    .MAC_LAT (1),
    .RT_LAT  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_req       (ch_req),
    .ch_ack       (ch_ack),
    .rf_num_taps  (rf_num_taps),
    .dp           (dp),
    .ch_out       (ch_out),
    .ch_ovf       (ch_ovf),
    .ch_ovf_clear (ch_ovf_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // auto mode tags each captured word with its capture cycle
  assign dp.rt_data = rt_auto ? 16'hC000 + cyc[15:0] : rt_fixed;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input int ack_cyc,
                      input logic [15:0] data);
    exp_t e;
    e.ch   = ch;
    e.cyc  = ack_cyc;
    e.data = data;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ch_ack != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("spurious_ack", 32'(ch_ack), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_vec", 32'(ch_ack), 32'(1 << mon_e.ch));
          chk("ack_cyc", cyc, mon_e.cyc);
          chk("ack_data", 32'(ch_out[16*mon_e.ch +: 16]),
              32'(mon_e.data));
        end
      end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
        mon_e = sbq.pop_front();
        chk("ack_missing", 32'(ch_ack), 32'(1 << mon_e.ch));
      end
    end
  end

  initial begin
    int c;
    rst          = 1'b1;
    ch_req       = 2'b00;
    rf_num_taps  = 7'd0;
    ch_ovf_clear = 2'b00;
    dp.rt_ovf    = 1'b0;
    rt_auto      = 1'b0;
    rt_fixed     = 16'h0000;
    tick(3);
    chk("rst_mac_en", 32'(dp.mac_en), 32'd0);
    chk("rst_tap", 32'(dp.tap_addr), 32'd0);
    chk("rst_ch_out", ch_out, 32'd0);
    chk("rst_ovf", 32'(ch_ovf), 32'd0);
    chk("rst_ack", 32'(ch_ack), 32'd0);
    rst = 1'b0;
    tick(2);

    // single request, 8 taps, mid-pass tap count change ignored
    c = cyc;
    ch_req      = 2'b01;
    rf_num_taps = 7'd8;
    rt_fixed    = 16'h1234;
    push(0, c + 14, 16'h1234);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 3) rf_num_taps = 7'd2;
      chk("t1_mac_en", 32'(dp.mac_en), 32'd1);
      chk("t1_tap", 32'(dp.tap_addr), 32'(k - 1));
      chk("t1_clr", 32'(dp.mac_clr), 32'(k == 1));
      chk("t1_ch", 32'(dp.mac_ch), 32'd0);
    end
    tick(1);
    chk("t1_mac_off", 32'(dp.mac_en), 32'd0);
    tick(4);
    chk("t1_ovf_clr", 32'(dp.rt_ovf_clear), 32'd1);
    tick(1);
    ch_req = 2'b00;
    chk("t1_out", 32'(ch_out[15:0]), 32'h1234);
    tick(2);
    chk("t1_idle", 32'(dp.mac_en), 32'd0);

    // reset at tap 3 of 8 abandons the pass
    rf_num_taps = 7'd8;
    ch_req      = 2'b01;
    tick(4);
    chk("t2_tap3", 32'(dp.tap_addr), 32'd3);
    rst = 1'b1;
    #1;
    chk("t2_mac_en", 32'(dp.mac_en), 32'd0);
    chk("t2_tap", 32'(dp.tap_addr), 32'd0);
    chk("t2_out", ch_out, 32'd0);
    chk("t2_ack", 32'(ch_ack), 32'd0);
    tick(2);
    rst      = 1'b0;
    c        = cyc;
    rt_fixed = 16'hBEEF;
    push(0, c + 14, 16'hBEEF);
    tick(1);
    chk("t2_regrant", 32'(dp.mac_en), 32'd1);
    chk("t2_tap0", 32'(dp.tap_addr), 32'd0);
    chk("t2_clr", 32'(dp.mac_clr), 32'd1);
    tick(13);
    ch_req = 2'b00;
    tick(1);

    // both channels continuous, N=4: pointer sits at 1
    rt_auto     = 1'b1;
    rf_num_taps = 7'd4;
    c           = cyc;
    ch_req      = 2'b11;
    push(1, c + 10, 16'hC000 + 16'(c + 9));
    push(0, c + 20, 16'hC000 + 16'(c + 19));
    push(1, c + 30, 16'hC000 + 16'(c + 29));
    push(0, c + 40, 16'hC000 + 16'(c + 39));
    tick(1);
    chk("t3_grant1", 32'(dp.mac_ch), 32'd1);
    tick(10);
    chk("t3_grant0", 32'(dp.mac_ch), 32'd0);
    tick(29);
    ch_req = 2'b00;
    tick(1);

    // overflow on ch1, clear in the capture cycle loses
    c         = cyc;
    ch_req    = 2'b10;
    dp.rt_ovf = 1'b1;
    push(1, c + 10, 16'hC000 + 16'(c + 9));
    tick(9);
    chk("t4_ovf_clr", 32'(dp.rt_ovf_clear), 32'd1);
    ch_ovf_clear = 2'b10;
    tick(1);
    chk("t4_ovf_set", 32'(ch_ovf), 32'h2);
    chk("t4_clr_low", 32'(dp.rt_ovf_clear), 32'd0);
    ch_ovf_clear = 2'b00;
    dp.rt_ovf    = 1'b0;
    c            = cyc;
    ch_req       = 2'b01;
    push(0, c + 10, 16'hC000 + 16'(c + 9));
    tick(10);
    ch_req = 2'b00;
    chk("t4_ovf_ch0", 32'(ch_ovf), 32'h2);
    ch_ovf_clear = 2'b10;
    tick(1);
    ch_ovf_clear = 2'b00;
    chk("t5_clear", 32'(ch_ovf), 32'h0);

    // zero taps behaves as one tap
    c           = cyc;
    rf_num_taps = 7'd0;
    ch_req      = 2'b01;
    push(0, c + 7, 16'hC000 + 16'(c + 6));
    tick(1);
    chk("t6_mac_en", 32'(dp.mac_en), 32'd1);
    chk("t6_clr", 32'(dp.mac_clr), 32'd1);
    chk("t6_tap", 32'(dp.tap_addr), 32'd0);
    tick(1);
    chk("t6_one_tap", 32'(dp.mac_en), 32'd0);
    tick(5);
    ch_req = 2'b00;

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(1);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
